// File: rtl/seq_pattern_detector_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the programmable serial pattern detector:
//   - FSM state encoding (legacy-compatible 2-bit constants plus an enum view)
//   - clamp_len : folds a requested pattern length into 1..max_len
//   - mask_bit  : one bit of the "compare only the last len bits" mask
// ---------------------------------------------------------------------------
package seq_det_pkg;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_HIT   = 2'd2;

    typedef enum logic [1:0] {
        FILL  = ST_FILL,
        ARMED = ST_ARMED,
        HIT   = ST_HIT
    } state_e;

    // A zero length would never match anything meaningful, so it is promoted
    // to 1; anything longer than the history register is cut down to it.
    function automatic int clamp_len(input int len, input int max_len);
        if (len < 1) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

    // Bit idx of the comparison mask is set when idx lies inside the pattern.
    function automatic logic mask_bit(input int idx, input int len);
        return (idx < len);
    endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Generic saturating event counter shared by the statistics blocks.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count one event this cycle
//   clr      : synchronous clear; wins over inc, but a coincident event is
//              not lost (counter loads 1 instead of 0)
//   cnt      : current count, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// seq_pattern_detector
// Run-time programmable serial pattern detector with a registered Moore match
// pulse and a saturating match counter.
//   clk, rst      : clock, asynchronous active-high reset
//   cfg_valid     : new configuration offered
//   cfg_ready     : configuration can be taken (low while in HIT)
//   cfg_pattern   : pattern, bit 0 = last bit of the sequence
//   cfg_len       : pattern length (0 -> 1, >MAX_LEN -> MAX_LEN)
//   cfg_overlap   : 1 = overlapping matches allowed
//   in_valid, in  : qualified serial data bit
//   clr_cnt       : synchronous clear of match_cnt
//   match         : one-cycle pulse per HIT cycle, two edges after the
//                   completing bit was sampled
//   match_cnt     : saturating count of HIT entries
// ---------------------------------------------------------------------------
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(8'b0000_1011),
    parameter int                 RST_LEN = 4,
    localparam int                LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in,
    input  logic               clr_cnt,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'(clamp_len(RST_LEN, MAX_LEN));
    localparam logic [LEN_W-1:0] FILL_MAX  = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_reg, pattern_next;
    logic [MAX_LEN-1:0] hist_reg, hist_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [LEN_W-1:0]   fill_reg, fill_next;
    logic               overlap_reg, overlap_next;
    state_e             state_reg, state_next;
    logic               match_reg;

    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_msk;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   cfg_len_c;
    logic               accept;
    logic               hit;
    logic               armed_now;
    logic               armed_inc;

    // Only the youngest len bits take part in the comparison.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_msk[gi] = mask_bit(gi, int'(len_reg));
        end
    endgenerate

    assign cfg_ready  = (state_reg != HIT);
    assign accept     = cfg_valid && cfg_ready;
    assign cfg_len_c  = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));

    // Newest bit enters at bit 0; the oldest falls off the top.
    assign hist_shift = (hist_reg << 1) | MAX_LEN'(in);
    assign fill_inc   = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + 1'b1;

    // "Armed" means one more valid bit would give len bits of history.
    // Widened by one bit so len-1 never underflows.
    assign armed_now  = ({1'b0, fill_reg} + (LEN_W + 1)'(1)) >= {1'b0, len_reg};
    assign armed_inc  = ({1'b0, fill_inc} + (LEN_W + 1)'(1)) >= {1'b0, len_reg};

    // A config accept swallows the data bit of the same cycle.
    assign hit = in_valid && !accept
              && (((hist_shift ^ pattern_reg) & len_msk) == '0)
              && (fill_inc >= len_reg);

    always_comb begin
        pattern_next = pattern_reg;
        len_next     = len_reg;
        overlap_next = overlap_reg;
        hist_next    = hist_reg;
        fill_next    = fill_reg;
        state_next   = state_reg;

        if (accept) begin
            pattern_next = cfg_pattern;
            len_next     = cfg_len_c;
            overlap_next = cfg_overlap;
            hist_next    = '0;
            fill_next    = '0;
            state_next   = (cfg_len_c == LEN_W'(1)) ? ARMED : FILL;
        end else if (in_valid) begin
            if (hit) begin
                state_next = HIT;
                if (overlap_reg) begin
                    hist_next = hist_shift;
                    fill_next = fill_inc;
                end else begin
                    // Next match must be built from len fresh bits.
                    hist_next = '0;
                    fill_next = '0;
                end
            end else begin
                hist_next  = hist_shift;
                fill_next  = fill_inc;
                state_next = armed_inc ? ARMED : FILL;
            end
        end else if (state_reg == HIT) begin
            // Overlap keeps fill >= len, so this lands in ARMED; after a
            // non-overlapping hit fill is 0 and only len==1 is armed.
            state_next = armed_now ? ARMED : FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_reg <= RST_PAT;
            len_reg     <= RST_LEN_C;
            overlap_reg <= 1'b1;
            hist_reg    <= '0;
            fill_reg    <= '0;
            state_reg   <= FILL;
            match_reg   <= 1'b0;
        end else begin
            pattern_reg <= pattern_next;
            len_reg     <= len_next;
            overlap_reg <= overlap_next;
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            state_reg   <= state_next;
            match_reg   <= (state_reg == HIT);
        end
    end

    assign match = match_reg;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (clr_cnt),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_detector
// Scoreboarded bench: the driver updates a behavioural model (bit queue since
// last clear, "last len bits equal pattern" rule) for every issued cycle and
// pushes the cycle in which a match pulse is due; a negedge monitor pops and
// compares whenever a pulse is due or seen. A second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
// ---------------------------------------------------------------------------
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_overlap;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       in_valid;
    logic       in_bit;
    logic       clr_cnt;
    logic       cfg_ready, cfg_ready2;
    logic       match, match2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    always #5 clk = ~clk;

    seq_pattern_detector #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in          (in_bit),
        .clr_cnt     (clr_cnt),
        .match       (match),
        .match_cnt   (match_cnt)
    );

    seq_pattern_detector #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready2),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in          (in_bit),
        .clr_cnt     (clr_cnt),
        .match       (match2),
        .match_cnt   (match_cnt2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];
    bit exp_now;

    // Behavioural model state
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ov;
    bit         m_in_hit;
    bit         m_acc;
    int         m_cnt;
    int         m_cnt2;
    bit         m_hist[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pat    = 8'b0000_1011;
        m_len    = 4;
        m_ov     = 1'b1;
        m_in_hit = 1'b0;
        m_acc    = 1'b0;
        m_cnt    = 0;
        m_cnt2   = 0;
        m_hist.delete();
    endtask

    function automatic bit model_hit();
        if (m_hist.size() < m_len) return 1'b0;
        for (int j = 0; j < m_len; j++) begin
            if (m_hist[m_hist.size() - 1 - j] != m_pat[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: drive, predict, wait for the edge, check counters/ready.
    task automatic cycle(input bit v, input bit b, input bit cv, input logic [7:0] cp,
                         input logic [3:0] cl, input bit co, input bit clr);
        bit hit;
        in_valid    = v;
        in_bit      = b;
        cfg_valid   = cv;
        cfg_pattern = cp;
        cfg_len     = cl;
        cfg_overlap = co;
        clr_cnt     = clr;

        hit   = 1'b0;
        m_acc = cv && !m_in_hit;
        if (m_acc) begin
            m_pat = cp;
            m_len = (cl == 0) ? 1 : ((int'(cl) > 8) ? 8 : int'(cl));
            m_ov  = co;
            m_hist.delete();
            $display("config accepted pattern %02h len %0d overlap %0b", cp, m_len, co);
        end else if (v) begin
            m_hist.push_back(b);
            if (m_hist.size() > 8) void'(m_hist.pop_front());
            hit = model_hit();
            if (hit && !m_ov) m_hist.delete();
        end
        if (clr) begin
            m_cnt  = hit ? 1 : 0;
            m_cnt2 = hit ? 1 : 0;
        end else if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3)  m_cnt2++;
        end
        m_in_hit = hit;
        // HIT after the coming edge, match register one edge later.
        if (hit) exp_q.push_back(cyc + 2);

        @(posedge clk);
        @(negedge clk);
        check("match_cnt", int'(match_cnt), m_cnt);
        check("match_cnt_w2", int'(match_cnt2), m_cnt2);
        check("cfg_ready", int'(cfg_ready), int'(!m_in_hit));
        check("cfg_ready_w2", int'(cfg_ready2), int'(!m_in_hit));
    endtask

    task automatic bit_in(input bit b);
        cycle(1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom), 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    // Holds cfg_valid until the model says it is taken; bounded.
    task automatic cfg_hold(input logic [7:0] p, input logic [3:0] l, input bit o, input bit clr);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b0, 1'b1, p, l, o, clr);
            if (m_acc) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL cfg_hold_timeout: config not taken within 10 cycles");
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_now = (exp_q.size() > 0) && (exp_q[0] == cyc);
        if (match || exp_now) begin
            n_checks++;
            if (match !== exp_now) begin
                n_fail++;
                $display("FAIL match_pulse: cycle %0d got %0b expected %0b", cyc, match, exp_now);
            end else begin
                $display("match pulse cycle %0d count %0d", cyc, match_cnt);
            end
        end
        if (match2 || exp_now) begin
            n_checks++;
            if (match2 !== exp_now) begin
                n_fail++;
                $display("FAIL match_pulse_w2: cycle %0d got %0b expected %0b", cyc, match2, exp_now);
            end
        end
        if (exp_now) void'(exp_q.pop_front());
    end

    initial begin
        bit s1[7];
        rst = 1'b1;
        in_valid = 1'b0; in_bit = 1'b0; cfg_valid = 1'b0; cfg_pattern = 8'h00;
        cfg_len = 4'd0; cfg_overlap = 1'b0; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_match", int'(match), 0);
        check("reset_cnt", int'(match_cnt), 0);
        check("reset_ready", int'(cfg_ready), 1);
        rst = 1'b0;

        // 1: reset defaults, overlapping 1011
        s1 = '{1, 0, 1, 1, 0, 1, 1};
        foreach (s1[i]) bit_in(s1[i]);
        idle(3);
        check("t1_cnt", int'(match_cnt), 2);

        // 2: same stream, non-overlapping
        cfg_hold(8'h0B, 4'd4, 1'b0, 1'b1);
        foreach (s1[i]) bit_in(s1[i]);
        idle(3);
        check("t2_cnt", int'(match_cnt), 1);

        // 3: all-ones length 8, back-to-back HITs, config held across HIT
        cfg_hold(8'hFF, 4'd8, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) bit_in(1'b1);
        check("t3_cnt", int'(match_cnt), 3);
        check("t3_ready_in_hit", int'(cfg_ready), 0);
        cfg_hold(8'h0B, 4'd4, 1'b1, 1'b1);
        idle(2);

        // 4: 1,-,0,-,-,1,1 with junk on in during gaps
        bit_in(1'b1); idle(1); bit_in(1'b0); idle(2); bit_in(1'b1); bit_in(1'b1);
        idle(3);
        check("t4_cnt", int'(match_cnt), 1);

        // 5/6b: len 0 -> 1, every 1 matches; 2-bit counter saturates
        cfg_hold(8'hA5, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) bit_in(1'b1);
        check("t5_cnt", int'(match_cnt), 5);
        check("t5_cnt_sat", int'(match_cnt2), 3);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
        check("t5_clr_hit", int'(match_cnt), 1);
        check("t5_clr_hit_w2", int'(match_cnt2), 1);
        bit_in(1'b0);
        bit_in(1'b1);
        // length above MAX_LEN is clamped to 8
        cfg_hold(8'hFF, 4'd15, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) bit_in(1'b1);
        idle(3);
        check("t5_clamp_cnt", int'(match_cnt), 1);

        // 6a: reset mid-stream loses history, restores default pattern
        cfg_hold(8'h0B, 4'd4, 1'b1, 1'b1);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_match", int'(match), 0);
        check("t6_rst_cnt", int'(match_cnt), 0);
        check("t6_rst_ready", int'(cfg_ready), 1);
        model_reset();
        exp_q.delete();
        rst = 1'b0;
        bit_in(1'b1);
        idle(2);
        check("t6_no_spurious", int'(match_cnt), 0);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        idle(3);
        check("t6_default_pat", int'(match_cnt), 1);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] cl;
            cl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 39) == 0),
                  8'($urandom), cl, 1'($urandom), ($urandom_range(0, 49) == 0));
        end
        idle(4);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
